// File: rtl/us_measure_scheduler_if.sv
// us_measure_scheduler_if
// Start/done/distance handshake between the measurement scheduler and the
// HC-SR04 measurement core.
//   start    : 1-cycle start pulse, scheduler -> core
//   done     : 1-cycle completion pulse, core -> scheduler
//   distance : core result in cm, valid in the cycle done is high
// Modports: master = scheduler side, slave = core side.
interface us_measure_scheduler_if;
  logic       start;
  logic       done;
  logic [8:0] distance;

  modport master (output start, input done, input distance);
  modport slave  (input start, output done, output distance);
endinterface

// File: rtl/us_measure_scheduler.sv
// us_measure_scheduler
// Sequences HC-SR04 measurements: issues start pulses on manual request or on a
// periodic auto timer, bounds each measurement with a timeout, enforces an idle
// recovery gap, holds the last accepted distance and exports the FSM state.
//
// Optional feature: define US_AVG_FILTER_EN to pass accepted samples through a
// 4-entry moving average before they reach distance_o.
//
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   auto_en_i      : level, 1 = periodic measurement mode
//   req_i          : 1-cycle manual measurement request
//   core           : handshake to the measurement core (master modport)
//   distance_o     : last accepted (optionally averaged) distance in cm
//   dist_valid_o   : 1-cycle pulse when distance_o updates
//   timeout_err_o  : sticky timeout flag, cleared by the next accepted sample
//   range_err_o    : sticky out-of-range flag, cleared by the next accepted sample
//   busy_o         : 1 whenever the FSM is not idle
//   state_o        : current FSM state
//
// state   | meaning
// IDLE    | waiting for a pending or fresh request / auto tick
// START   | core start pulse for one cycle, timeout counter cleared
// WAIT    | waiting for core done, bounded by the timeout counter
// CAPTURE | range-check the latched sample, update distance or flag error
// ERROR   | measurement timed out, flag error
// GAP     | sensor recovery gap before the next measurement
module us_measure_scheduler #(
  parameter int unsigned PERIOD_CYCLES  = 10_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 3_000_000,
  parameter int unsigned GAP_CYCLES     = 6_000_000,
  parameter logic [8:0]  MIN_DIST       = 9'd2,
  parameter logic [8:0]  MAX_DIST       = 9'd400
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          auto_en_i,
  input  logic                          req_i,
  us_measure_scheduler_if.master        core,
  output logic [8:0]                    distance_o,
  output logic                          dist_valid_o,
  output logic                          timeout_err_o,
  output logic                          range_err_o,
  output logic                          busy_o,
  output logic [2:0]                    state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_ERROR   = 3'd4,
    S_GAP     = 3'd5
  } state_t;

  localparam logic [31:0] PER_TC = 32'(PERIOD_CYCLES - 1);
  localparam logic [31:0] TO_TC  = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] GAP_TC = 32'(GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] per_cnt_q, per_cnt_d;
  logic [31:0] to_cnt_q, to_cnt_d;
  logic [31:0] gap_cnt_q, gap_cnt_d;
  logic        man_pend_q, man_pend_d;
  logic        auto_pend_q, auto_pend_d;
  logic [8:0]  sample_q, sample_d;
  logic [8:0]  distance_q, distance_d;
  logic        timeout_err_q, timeout_err_d;
  logic        range_err_q, range_err_d;

  logic        tick;
  logic        go;
  logic        in_range;
  logic        accept;
  logic [8:0]  new_dist;

  // Period timer and pending flags
  always_comb begin
    tick = auto_en_i && (per_cnt_q == PER_TC);
    if (!auto_en_i || tick) per_cnt_d = '0;
    else                    per_cnt_d = per_cnt_q + 32'd1;

    go = man_pend_q | auto_pend_q | req_i | tick;

    // Clearing on the IDLE->START transition wins over a same-cycle set, so a
    // coincident req and tick produce one measurement only.
    if (state_q == S_IDLE && go) man_pend_d = 1'b0;
    else                         man_pend_d = man_pend_q | req_i;

    if (!auto_en_i || (state_q == S_IDLE && go)) auto_pend_d = 1'b0;
    else                                         auto_pend_d = auto_pend_q | tick;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:    state_d = go ? S_START : S_IDLE;
      S_START:   state_d = S_WAIT;
      S_WAIT: begin
        if (core.done)               state_d = S_CAPTURE;
        else if (to_cnt_q == TO_TC)  state_d = S_ERROR;
        else                         state_d = S_WAIT;
      end
      S_CAPTURE: state_d = S_GAP;
      S_ERROR:   state_d = S_GAP;
      S_GAP:     state_d = (gap_cnt_q == GAP_TC) ? S_IDLE : S_GAP;
      default:   state_d = S_IDLE;
    endcase
  end

  // Sample qualification and optional averaging
  always_comb begin
    in_range = (sample_q >= MIN_DIST) && (sample_q <= MAX_DIST);
    accept   = (state_q == S_CAPTURE) && in_range;
  end

`ifdef US_AVG_FILTER_EN
  logic [8:0]  win_q [4];
  logic        primed_q;
  logic [10:0] win_sum;

  always_comb begin
    win_sum = {2'b00, win_q[0]} + {2'b00, win_q[1]} + {2'b00, win_q[2]}
            + {2'b00, sample_q};
    // Before the window is primed it is filled with the sample itself, so the
    // average equals the sample.
    new_dist = primed_q ? 9'(win_sum >> 2) : sample_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) win_q[i] <= '0;
      primed_q <= 1'b0;
    end else if (accept) begin
      primed_q <= 1'b1;
      if (!primed_q) begin
        for (int i = 0; i < 4; i++) win_q[i] <= sample_q;
      end else begin
        win_q[3] <= win_q[2];
        win_q[2] <= win_q[1];
        win_q[1] <= win_q[0];
        win_q[0] <= sample_q;
      end
    end
  end
`else
  always_comb new_dist = sample_q;
`endif

  // Datapath next-state
  always_comb begin
    to_cnt_d      = to_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    sample_d      = sample_q;
    distance_d    = distance_q;
    timeout_err_d = timeout_err_q;
    range_err_d   = range_err_q;

    case (state_q)
      S_START: to_cnt_d = '0;
      S_WAIT: begin
        if (to_cnt_q != TO_TC) to_cnt_d = to_cnt_q + 32'd1;
        if (core.done)         sample_d = core.distance;
      end
      S_CAPTURE: begin
        gap_cnt_d = '0;
        if (in_range) begin
          distance_d    = new_dist;
          timeout_err_d = 1'b0;
          range_err_d   = 1'b0;
        end else begin
          range_err_d = 1'b1;
        end
      end
      S_ERROR: begin
        gap_cnt_d     = '0;
        timeout_err_d = 1'b1;
      end
      S_GAP: if (gap_cnt_q != GAP_TC) gap_cnt_d = gap_cnt_q + 32'd1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      per_cnt_q     <= '0;
      to_cnt_q      <= '0;
      gap_cnt_q     <= '0;
      man_pend_q    <= 1'b0;
      auto_pend_q   <= 1'b0;
      sample_q      <= '0;
      distance_q    <= '0;
      timeout_err_q <= 1'b0;
      range_err_q   <= 1'b0;
    end else begin
      per_cnt_q     <= per_cnt_d;
      to_cnt_q      <= to_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      man_pend_q    <= man_pend_d;
      auto_pend_q   <= auto_pend_d;
      sample_q      <= sample_d;
      distance_q    <= distance_d;
      timeout_err_q <= timeout_err_d;
      range_err_q   <= range_err_d;
    end
  end

  // Outputs. The accepted value is forwarded during CAPTURE so distance_o is
  // already updated in the cycle dist_valid_o pulses.
  always_comb begin
    core.start    = (state_q == S_START);
    busy_o        = (state_q != S_IDLE);
    state_o       = state_q;
    dist_valid_o  = accept;
    distance_o    = accept ? new_dist : distance_q;
    timeout_err_o = timeout_err_q;
    range_err_o   = range_err_q;
  end

endmodule

// File: tb/tb_us_measure_scheduler.sv
// tb_us_measure_scheduler
// Directed bench for us_measure_scheduler with short simulation timings
// (period 1000, timeout 200, gap 50). Inputs change and outputs are sampled on
// the falling clock edge.
module tb_us_measure_scheduler;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       auto_en = 1'b0;
  logic       req = 1'b0;
  logic [8:0] distance;
  logic       dist_valid, timeout_err, range_err, busy;
  logic [2:0] state;

  int nvec = 0;
  int nerr = 0;

`ifdef US_AVG_FILTER_EN
  localparam logic [8:0] EXP_T2 = 9'd104;  // (123*3 + 50) >> 2
  localparam logic [8:0] EXP_T3 = 9'd174;  // (50 + 123 + 123 + 400) >> 2
`else
  localparam logic [8:0] EXP_T2 = 9'd50;
  localparam logic [8:0] EXP_T3 = 9'd400;
`endif

  us_measure_scheduler_if core_if ();

  us_measure_scheduler #(
    .PERIOD_CYCLES (1000),
    .TIMEOUT_CYCLES(200),
    .GAP_CYCLES    (50),
    .MIN_DIST      (9'd2),
    .MAX_DIST      (9'd400)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .auto_en_i    (auto_en),
    .req_i        (req),
    .core         (core_if),
    .distance_o   (distance),
    .dist_valid_o (dist_valid),
    .timeout_err_o(timeout_err),
    .range_err_o  (range_err),
    .busy_o       (busy),
    .state_o      (state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (state == 3'd0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Request a measurement from IDLE and answer with d after dly extra WAIT
  // cycles; returns at the CAPTURE falling edge.
  task automatic do_measure(input logic [8:0] d, input int dly);
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    repeat (dly) tick();
    core_if.distance = d;
    core_if.done = 1'b1;
    tick();
    core_if.done = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    if ({core_if.start, distance, dist_valid, timeout_err, range_err, busy, state} !== 17'd0) begin
      $display("FAIL reset_outputs: got %h expected 0",
               {core_if.start, distance, dist_valid, timeout_err, range_err, busy, state});
      nerr++;
    end
    nvec++;
  endtask

  task automatic test_manual();
    req = 1'b1;
    tick();
    req = 1'b0;
    if (core_if.start !== 1'b1 || state !== 3'd1) begin
      $display("FAIL start_next_cycle: start=%b state=%0d expected 1/1", core_if.start, state);
      nerr++;
    end
    nvec++;
    tick();
    if (core_if.start !== 1'b0 || state !== 3'd2) begin
      $display("FAIL start_one_cycle: start=%b state=%0d expected 0/2", core_if.start, state);
      nerr++;
    end
    nvec++;
    repeat (38) tick();
    core_if.distance = 9'd123;
    core_if.done = 1'b1;
    tick();
    core_if.done = 1'b0;
    if (state !== 3'd3 || dist_valid !== 1'b1 || distance !== 9'd123) begin
      $display("FAIL manual_capture: state=%0d valid=%b dist=%0d expected 3/1/123",
               state, dist_valid, distance);
      nerr++;
    end
    nvec++;
    tick();
    if (state !== 3'd5 || dist_valid !== 1'b0 || distance !== 9'd123) begin
      $display("FAIL manual_gap_entry: state=%0d valid=%b dist=%0d expected 5/0/123",
               state, dist_valid, distance);
      nerr++;
    end
    nvec++;
    repeat (49) tick();
    if (busy !== 1'b1) begin
      $display("FAIL gap_last_cycle: busy=%b expected 1", busy);
      nerr++;
    end
    nvec++;
    tick();
    if (busy !== 1'b0 || state !== 3'd0) begin
      $display("FAIL gap_end: busy=%b state=%0d expected 0/0", busy, state);
      nerr++;
    end
    nvec++;
  endtask

  task automatic test_timeout();
    int cnt;
    bit ok;
    cnt = 0;
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    while (state == 3'd2 && cnt < 300) begin
      cnt++;
      tick();
    end
    if (cnt != 200 || state !== 3'd4) begin
      $display("FAIL timeout_len: wait_cycles=%0d state=%0d expected 200/4", cnt, state);
      nerr++;
    end
    nvec++;
    tick();
    if (timeout_err !== 1'b1 || distance !== 9'd123 || state !== 3'd5) begin
      $display("FAIL timeout_flag: err=%b dist=%0d state=%0d expected 1/123/5",
               timeout_err, distance, state);
      nerr++;
    end
    nvec++;
    wait_idle(ok);
    if (!ok) begin
      $display("FAIL timeout_idle: never returned to IDLE, state=%0d", state);
      nerr++;
    end
    nvec++;
    do_measure(9'd50, 10);
    if (dist_valid !== 1'b1 || distance !== EXP_T2) begin
      $display("FAIL after_timeout_sample: valid=%b dist=%0d expected 1/%0d",
               dist_valid, distance, EXP_T2);
      nerr++;
    end
    nvec++;
    tick();
    if (timeout_err !== 1'b0) begin
      $display("FAIL timeout_clear: err=%b expected 0", timeout_err);
      nerr++;
    end
    nvec++;
  endtask

  task automatic test_range();
    bit ok;
    logic [8:0] bad [2];
    bad[0] = 9'd401;
    bad[1] = 9'd1;
    for (int k = 0; k < 2; k++) begin
      wait_idle(ok);
      do_measure(bad[k], 5);
      if (!ok || dist_valid !== 1'b0 || distance !== EXP_T2) begin
        $display("FAIL range_reject_%0d: idle=%b valid=%b dist=%0d expected 1/0/%0d",
                 bad[k], ok, dist_valid, distance, EXP_T2);
        nerr++;
      end
      nvec++;
      tick();
      if (range_err !== 1'b1) begin
        $display("FAIL range_flag_%0d: err=%b expected 1", bad[k], range_err);
        nerr++;
      end
      nvec++;
    end
    wait_idle(ok);
    do_measure(9'd400, 5);
    if (!ok || dist_valid !== 1'b1 || distance !== EXP_T3) begin
      $display("FAIL range_max_accept: idle=%b valid=%b dist=%0d expected 1/1/%0d",
               ok, dist_valid, distance, EXP_T3);
      nerr++;
    end
    nvec++;
    tick();
    if (range_err !== 1'b0) begin
      $display("FAIL range_clear: err=%b expected 0", range_err);
      nerr++;
    end
    nvec++;
  endtask

  task automatic test_auto();
    bit ok;
    int first, c1, c2, f2;
    first = 0; c1 = 0; c2 = 0; f2 = 0;
    wait_idle(ok);
    auto_en = 1'b1;
    for (int i = 1; i <= 1100; i++) begin
      tick();
      if (core_if.start === 1'b1) begin
        first = i;
        break;
      end
    end
    if (!ok || first != 1000) begin
      $display("FAIL auto_first_start: idle=%b cycle=%0d expected 1/1000", ok, first);
      nerr++;
    end
    nvec++;
    core_if.distance = 9'd60;
    for (int i = 1; i <= 1400; i++) begin
      tick();
      if (core_if.start === 1'b1) begin
        if (i <= 990) c1++;
        else begin
          c2++;
          if (f2 == 0) f2 = i;
        end
      end
      core_if.done = (i == 1);
      req = (i == 10 || i == 12 || i == 14 || i == 999);
    end
    req = 1'b0;
    core_if.done = 1'b0;
    if (c1 != 1) begin
      $display("FAIL coalesce_gap_reqs: starts=%0d expected 1", c1);
      nerr++;
    end
    nvec++;
    if (f2 != 1000) begin
      $display("FAIL auto_period: start_at=%0d expected 1000", f2);
      nerr++;
    end
    nvec++;
    if (c2 != 1) begin
      $display("FAIL coalesce_req_tick: starts=%0d expected 1", c2);
      nerr++;
    end
    nvec++;
    auto_en = 1'b0;
    tick();
  endtask

  task automatic test_robust();
    bit ok;
    int first, cnt;
    do_reset();
    do_measure(9'd77, 5);
    if (distance !== 9'd77 || dist_valid !== 1'b1) begin
      $display("FAIL robust_sample: dist=%0d valid=%b expected 77/1", distance, dist_valid);
      nerr++;
    end
    nvec++;
    tick();
    core_if.distance = 9'd300;
    core_if.done = 1'b1;
    tick();
    core_if.done = 1'b0;
    if (state !== 3'd5 || distance !== 9'd77 || dist_valid !== 1'b0 || range_err !== 1'b0) begin
      $display("FAIL done_in_gap: state=%0d dist=%0d valid=%b rerr=%b expected 5/77/0/0",
               state, distance, dist_valid, range_err);
      nerr++;
    end
    nvec++;
    wait_idle(ok);
    core_if.distance = 9'd301;
    core_if.done = 1'b1;
    tick();
    core_if.done = 1'b0;
    tick();
    if (!ok || state !== 3'd0 || distance !== 9'd77 || dist_valid !== 1'b0) begin
      $display("FAIL done_in_idle: idle=%b state=%0d dist=%0d valid=%b expected 1/0/77/0",
               ok, state, distance, dist_valid);
      nerr++;
    end
    nvec++;
    req = 1'b1;
    tick();
    req = 1'b0;
    reset = 1'b1;
    #1;
    if (core_if.start !== 1'b0 || state !== 3'd0) begin
      $display("FAIL reset_in_start: start=%b state=%0d expected 0/0", core_if.start, state);
      nerr++;
    end
    nvec++;
    tick();
    reset = 1'b0;
    tick();
    do_measure(9'd55, 3);
    tick();
    req = 1'b1;
    tick();
    req = 1'b0;
    wait_idle(ok);
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    repeat (5) tick();
    reset = 1'b1;
    #1;
    if ({core_if.start, distance, dist_valid, timeout_err, range_err, busy, state} !== 17'd0) begin
      $display("FAIL reset_in_wait: got %h expected 0",
               {core_if.start, distance, dist_valid, timeout_err, range_err, busy, state});
      nerr++;
    end
    nvec++;
    tick();
    reset = 1'b0;
    tick();
    first = 0;
    auto_en = 1'b1;
    for (int i = 1; i <= 1100; i++) begin
      tick();
      if (core_if.start === 1'b1) begin
        first = i;
        break;
      end
    end
    tick();
    auto_en = 1'b0;
    repeat (3) tick();
    core_if.distance = 9'd90;
    core_if.done = 1'b1;
    tick();
    core_if.done = 1'b0;
    if (first != 1000 || dist_valid !== 1'b1 || distance !== 9'd90) begin
      $display("FAIL auto_drop_completes: start_at=%0d valid=%b dist=%0d expected 1000/1/90",
               first, dist_valid, distance);
      nerr++;
    end
    nvec++;
    cnt = 0;
    for (int i = 0; i < 1500; i++) begin
      tick();
      if (core_if.start === 1'b1) cnt++;
    end
    if (cnt != 0) begin
      $display("FAIL auto_drop_no_starts: starts=%0d expected 0", cnt);
      nerr++;
    end
    nvec++;
  endtask

  task automatic test_filter();
    bit ok;
    logic [8:0] smp [4];
    logic [8:0] exp_d [4];
    smp[0] = 9'd100; smp[1] = 9'd200; smp[2] = 9'd200; smp[3] = 9'd200;
`ifdef US_AVG_FILTER_EN
    exp_d[0] = 9'd100; exp_d[1] = 9'd125; exp_d[2] = 9'd150; exp_d[3] = 9'd175;
`else
    exp_d[0] = 9'd100; exp_d[1] = 9'd200; exp_d[2] = 9'd200; exp_d[3] = 9'd200;
`endif
    do_reset();
    for (int k = 0; k < 4; k++) begin
      wait_idle(ok);
      do_measure(smp[k], 3);
      if (!ok || dist_valid !== 1'b1 || distance !== exp_d[k]) begin
        $display("FAIL filter_step_%0d: idle=%b valid=%b dist=%0d expected 1/1/%0d",
                 k, ok, dist_valid, distance, exp_d[k]);
        nerr++;
      end
      nvec++;
    end
  endtask

  initial begin
    core_if.done = 1'b0;
    core_if.distance = 9'd0;
    test_reset();
    test_manual();
    test_timeout();
    test_range();
    test_auto();
    test_robust();
    test_filter();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr + 1);
    $fatal(1);
  end
endmodule
